// File: rtl/rr_arb_4x1.sv
// Four-channel round-robin arbiter that drives the select and handshake of a downstream 4:1 mux.
// Optional packet lock (hold the grant until in_last) is enabled by defining ARB_PKT_LOCK_EN.
`timescale 1ns/1ps

module rr_arb_4x1 #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH-1:0] in_last,
  output logic [NUM_CH-1:0] in_ready,
  output logic [1:0]        select,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  // The 2-bit select only addresses four inputs.
  if (NUM_CH != 4) begin : gen_bad_num_ch
    $error("rr_arb_4x1: NUM_CH must be 4");
  end

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  localparam logic [NUM_CH-1:0] OneHot0 = NUM_CH'(1);

  logic       state_q, state_d;
  logic [1:0] select_q, select_d;
  logic [1:0] ptr_q, ptr_d;

  logic              xfer;
  logic              lock_hold;
  logic [1:0]        next_sel;
  logic [NUM_CH-1:0] masked;

  // First set bit of req, searching start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign xfer     = (state_q == StBusy) && in_valid[select_q] && out_ready;
  assign next_sel = select_q + 2'd1;
  assign masked   = in_valid & ~(OneHot0 << select_q);

`ifdef ARB_PKT_LOCK_EN
  // Mid-packet beats keep the grant; only the last beat releases it.
  assign lock_hold = xfer && !in_last[select_q];
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    if (state_q == StIdle) begin
      if (|in_valid) begin
        select_d = rr_pick(in_valid, ptr_q);
        state_d  = StBusy;
      end
    end else begin
      if (xfer && !lock_hold) begin
        ptr_d = next_sel;
        if (|masked) begin
          select_d = rr_pick(masked, next_sel);
        end else begin
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      select_q <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
    end
  end

  assign busy      = (state_q == StBusy);
  assign select    = select_q;
  assign out_valid = busy && in_valid[select_q];
  assign in_ready  = (busy && out_ready) ? (OneHot0 << select_q) : '0;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_select_stable : assert property (@(posedge clk) disable iff (rst)
                                     (out_valid && !out_ready) |=> $stable(select));

endmodule

// File: tb/tb_rr_arb_4x1.sv
// Directed bench for rr_arb_4x1: fairness order, single-channel bubble, stall, reset, packet lock.
`timescale 1ns/1ps

module tb_rr_arb_4x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic [1:0] select;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rr_arb_4x1 #(.NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int seq_all[5] = '{0, 1, 2, 3, 0};
  int ov_pat[4]  = '{1, 0, 1, 0};
`ifdef ARB_PKT_LOCK_EN
  int pkt_seq[4] = '{3, 3, 3, 0};
`else
  int pkt_seq[4] = '{3, 0, 3, 0};
`endif

  initial begin
    // Reset state with all channels requesting
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_select", int'(select), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    tick();
    check("grant_busy", int'(busy), 1);
    check("grant_select", int'(select), 0);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_select", int'(select), seq_all[k]);
      check("rr_in_ready", int'(in_ready), 1 << seq_all[k]);
      check("rr_out_valid", int'(out_valid), 1);
      tick();
    end

    // Single requester: one beat every other cycle
    do_reset();
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("single_out_valid", int'(out_valid), ov_pat[k]);
      check("single_select", int'(select), 2);
      tick();
    end

    // Stall with two requesters: grant must not move
    do_reset();
    in_valid  = 4'b0101;
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_select", int'(select), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", int'(in_ready), 1);
    tick();
    check("unstall_select", int'(select), 2);

    // Reset during a pending grant to ch1
    do_reset();
    in_valid = 4'b0010;
    tick();
    check("pend_select", int'(select), 1);
    check("pend_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("pend_in_ready", int'(in_ready), 0);
    tick();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_select", int'(select), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    rst      = 1'b0;
    in_valid = 4'b1111;
    tick();
    // A pointer reset to 0 makes ch0 win against all four
    check("mid_rst_ptr", int'(select), 0);

    // Three-beat packet on ch3 against a waiting ch0
    do_reset();
    in_valid = 4'b1000;
    tick();
    check("pkt_grant", int'(select), 3);
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_last = (k == 2) ? 4'b1000 : 4'b0000;
      #1;
      check("pkt_select", int'(select), pkt_seq[k]);
      check("pkt_out_valid", int'(out_valid), 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
